// File: rtl/muldiv_defs_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op codes, FSM states,
// accumulate modes and the magnitude helper used by signed divides.
package muldiv_defs;

  typedef enum logic [3:0] {
    MULDIV_NOP = 4'd0,
    MULT       = 4'd1,
    MULTU      = 4'd2,
    DIV        = 4'd3,
    DIVU       = 4'd4,
    MTHI       = 4'd5,
    MTLO       = 4'd6,
    MADD       = 4'd7,
    MADDU      = 4'd8,
    MSUB       = 4'd9,
    MSUBU      = 4'd10
  } op_e;

  // State names carry an ST_ prefix because DIV is already an op code.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ACC_NONE = 2'd0,
    ACC_ADD  = 2'd1,
    ACC_SUB  = 2'd2
  } acc_e;

  localparam int DIV_ITERATIONS = 32;
  localparam int CNT_W          = 5;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider: i_load primes the registers, each i_step
// retires one quotient bit (MSB first); 32 steps complete a divide.
module muldiv_div_core
  import muldiv_defs::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_divisor;
  logic [32:0] w_shifted;
  logic        w_fits;

  // The partial remainder is always below the divisor, so one extra bit
  // is enough to hold the shifted trial value.
  assign w_shifted = {r_rem, r_quo[31]};
  assign w_fits    = (w_shifted >= {1'b0, r_divisor});

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rem     <= '0;
      r_quo     <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_rem     <= '0;
      r_quo     <= i_dividend;
      r_divisor <= i_divisor;
    end else if (i_step) begin
      if (w_fits) begin
        r_rem <= 32'(w_shifted - {1'b0, r_divisor});
        r_quo <= {r_quo[30:0], 1'b1};
      end else begin
        r_rem <= w_shifted[31:0];
        r_quo <= {r_quo[30:0], 1'b0};
      end
    end
  end

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MULDIV_ACCUM_EN to
// add MADD/MADDU/MSUB/MSUBU accumulate ops on the multiply path.
module hilo_muldiv_unit
  import muldiv_defs::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [3:0]  Op,
  input  logic [31:0] OperandA,
  input  logic [31:0] OperandB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ReadDataHi,
  output logic [31:0] ReadDataLo
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_ITERATIONS - 1);

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic             r_done;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_signed;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
`ifdef MULDIV_ACCUM_EN
  acc_e             r_acc;
`endif

  op_e         w_op;
  logic        w_accept;
  logic        w_is_div;
  logic        w_sdiv;
  logic        w_div_step;
  logic [31:0] w_quotient;
  logic [31:0] w_remainder;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_product;
  logic [63:0] w_mul_result;
  logic [31:0] w_div_lo;
  logic [31:0] w_div_hi;

  assign w_op       = op_e'(Op);
  assign w_accept   = (r_state == ST_IDLE) && Start;
  assign w_is_div   = (w_op == DIV) || (w_op == DIVU);
  assign w_sdiv     = (w_op == DIV);
  assign w_div_step = (r_state == ST_DIV);

  muldiv_div_core u_div_core (
    .i_clk       (Clk),
    .i_rst       (Reset),
    .i_load      (w_accept && w_is_div),
    .i_step      (w_div_step),
    .i_dividend  (abs32(OperandA, w_sdiv)),
    .i_divisor   (abs32(OperandB, w_sdiv)),
    .o_quotient  (w_quotient),
    .o_remainder (w_remainder)
  );

  // Sign-extending to 64 bits makes the truncated 64x64 product correct for
  // both signed and unsigned operands with a single multiplier.
  assign w_ext_a   = {{32{r_signed & r_op_a[31]}}, r_op_a};
  assign w_ext_b   = {{32{r_signed & r_op_b[31]}}, r_op_b};
  assign w_product = w_ext_a * w_ext_b;

`ifdef MULDIV_ACCUM_EN
  always_comb begin
    // NOTE: combinational outputs get a full assignment on every path
    // (here via default) so no latch is inferred.
    unique case (r_acc)
      ACC_ADD: w_mul_result = {r_hi, r_lo} + w_product;
      ACC_SUB: w_mul_result = {r_hi, r_lo} - w_product;
      default: w_mul_result = w_product;
    endcase
  end
`else
  assign w_mul_result = w_product;
`endif

  // Divide-by-zero returns all-ones quotient and the untouched signed dividend.
  assign w_div_lo = r_div0 ? 32'hFFFF_FFFF : (r_neg_q ? (~w_quotient + 32'd1) : w_quotient);
  assign w_div_hi = r_div0 ? r_op_a : (r_neg_r ? (~w_remainder + 32'd1) : w_remainder);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      // NOTE: operand latches carry nothing across operations, but resetting
      // them keeps every flop at a known value out of reset.
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_signed <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
`ifdef MULDIV_ACCUM_EN
      r_acc    <= ACC_NONE;
`endif
    end else begin
      // NOTE: all sequential state uses non-blocking assignment so every
      // register samples pre-edge values regardless of statement order.
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (Start) begin
            case (w_op)
              MULT, MULTU: begin
                r_op_a   <= OperandA;
                r_op_b   <= OperandB;
                r_signed <= (w_op == MULT);
                r_cnt    <= MUL_LOAD;
                r_state  <= ST_MUL;
`ifdef MULDIV_ACCUM_EN
                r_acc    <= ACC_NONE;
`endif
              end
`ifdef MULDIV_ACCUM_EN
              MADD, MADDU, MSUB, MSUBU: begin
                r_op_a   <= OperandA;
                r_op_b   <= OperandB;
                r_signed <= (w_op == MADD) || (w_op == MSUB);
                r_acc    <= ((w_op == MADD) || (w_op == MADDU)) ? ACC_ADD : ACC_SUB;
                r_cnt    <= MUL_LOAD;
                r_state  <= ST_MUL;
              end
`endif
              DIV, DIVU: begin
                r_op_a  <= OperandA;
                r_neg_q <= w_sdiv && (OperandA[31] ^ OperandB[31]);
                r_neg_r <= w_sdiv && OperandA[31];
                r_div0  <= (OperandB == 32'd0);
                r_cnt   <= DIV_LOAD;
                r_state <= ST_DIV;
              end
              MTHI:    r_hi <= OperandA;
              MTLO:    r_lo <= OperandA;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (r_cnt == '0) begin
            {r_hi, r_lo} <= w_mul_result;
            r_done       <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (r_cnt == '0) begin
            r_state <= ST_FIX;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_FIX: begin
          r_lo    <= w_div_lo;
          r_hi    <= w_div_hi;
          r_done  <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy       = (r_state != ST_IDLE);
  assign Done       = r_done;
  assign ReadDataHi = r_hi;
  assign ReadDataLo = r_lo;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed self-checking bench for hilo_muldiv_unit; inputs change and outputs
// are sampled on the falling edge of Clk.
module tb_hilo_muldiv_unit;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  Op;
  logic [31:0] OperandA;
  logic [31:0] OperandB;
  logic        Busy;
  logic        Done;
  logic [31:0] ReadDataHi;
  logic [31:0] ReadDataLo;

  int total = 0;
  int bad   = 0;
  int n;

  hilo_muldiv_unit #(.MUL_CYCLES(4)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .Op         (Op),
    .OperandA   (OperandA),
    .OperandB   (OperandB),
    .Busy       (Busy),
    .Done       (Done),
    .ReadDataHi (ReadDataHi),
    .ReadDataLo (ReadDataLo)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Start    = 1'b1;
    Op       = op;
    OperandA = a;
    OperandB = b;
    @(negedge Clk);
    Start    = 1'b0;
  endtask

  // Counts cycles with Busy high; bounded so a stuck DUT still terminates.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (Busy === 1'b1 && cycles < 200) begin
      @(negedge Clk);
      cycles++;
    end
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Op = 4'd0; OperandA = '0; OperandB = '0;
    repeat (2) @(negedge Clk);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);
    check("rst_hi", ReadDataHi, 32'd0);
    check("rst_lo", ReadDataLo, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);

    // MTHI writes immediately, no busy, no done
    issue(4'd5, 32'h1111_1111, 32'd0);
    check("mthi_hi", ReadDataHi, 32'h1111_1111);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    check("mthi_done", {31'd0, Done}, 32'd0);

    // MULT -3 * 5
    issue(4'd1, 32'hFFFF_FFFD, 32'd5);
    check("mult_hi_during_busy", ReadDataHi, 32'h1111_1111);
    wait_idle(n);
    check("mult_busy_cycles", n, 32'd4);
    check("mult_done", {31'd0, Done}, 32'd1);
    check("mult_hi", ReadDataHi, 32'hFFFF_FFFF);
    check("mult_lo", ReadDataLo, 32'hFFFF_FFF1);
    @(negedge Clk);
    check("mult_done_pulse", {31'd0, Done}, 32'd0);

    // MULTU 0xFFFFFFFF * 2
    issue(4'd2, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_hi", ReadDataHi, 32'h0000_0001);
    check("multu_lo", ReadDataLo, 32'hFFFF_FFFE);
    @(negedge Clk);

    // DIV -7 / 2 with an MTHI issued while busy that must be ignored
    issue(4'd3, 32'hFFFF_FFF9, 32'd2);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      if (n == 4) begin
        Start = 1'b1; Op = 4'd5; OperandA = 32'h0000_1234;
      end else begin
        Start = 1'b0;
      end
      @(negedge Clk);
      n++;
    end
    Start = 1'b0;
    check("div_busy_cycles", n, 32'd33);
    check("div_done", {31'd0, Done}, 32'd1);
    check("div_lo", ReadDataLo, 32'hFFFF_FFFD);
    check("div_hi", ReadDataHi, 32'hFFFF_FFFF);
    @(negedge Clk);

    // DIVU 7 / 0
    issue(4'd4, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0_busy_cycles", n, 32'd33);
    check("divu0_lo", ReadDataLo, 32'hFFFF_FFFF);
    check("divu0_hi", ReadDataHi, 32'h0000_0007);
    @(negedge Clk);

    // Signed overflow case
    issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", ReadDataLo, 32'h8000_0000);
    check("divovf_hi", ReadDataHi, 32'h0000_0000);
    @(negedge Clk);

    // 100 / -7 : quotient -14, remainder +2
    issue(4'd3, 32'd100, 32'hFFFF_FFF9);
    wait_idle(n);
    check("divneg_lo", ReadDataLo, 32'hFFFF_FFF2);
    check("divneg_hi", ReadDataHi, 32'h0000_0002);
    @(negedge Clk);

    // Signed divide by zero keeps the original negative dividend
    issue(4'd3, 32'hFFFF_FFF8, 32'd0);
    wait_idle(n);
    check("div0s_lo", ReadDataLo, 32'hFFFF_FFFF);
    check("div0s_hi", ReadDataHi, 32'hFFFF_FFF8);
    @(negedge Clk);

    // Back-to-back: MTLO accepted in the Done cycle of a MULT
    issue(4'd2, 32'd7, 32'd6);
    wait_idle(n);
    check("b2b_done", {31'd0, Done}, 32'd1);
    check("b2b_mul_lo", ReadDataLo, 32'd42);
    issue(4'd6, 32'h0000_0055, 32'd0);
    check("b2b_mtlo_lo", ReadDataLo, 32'h0000_0055);
    check("b2b_hi", ReadDataHi, 32'd0);

    // Undefined op code is ignored
    issue(4'd15, 32'hDEAD_BEEF, 32'd3);
    check("undef_busy", {31'd0, Busy}, 32'd0);
    check("undef_lo", ReadDataLo, 32'h0000_0055);

    // Async reset in the middle of a divide
    issue(4'd5, 32'h0000_0099, 32'd0);
    issue(4'd3, 32'd100, 32'd3);
    repeat (9) @(negedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, Busy}, 32'd0);
    check("midrst_hi", ReadDataHi, 32'd0);
    check("midrst_lo", ReadDataLo, 32'd0);
    @(negedge Clk);
    check("midrst_done", {31'd0, Done}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    issue(4'd6, 32'h0000_ABCD, 32'd0);
    check("postrst_lo", ReadDataLo, 32'h0000_ABCD);
    check("postrst_busy", {31'd0, Busy}, 32'd0);
    check("postrst_done", {31'd0, Done}, 32'd0);

    // Accumulate ops
    issue(4'd5, 32'd1, 32'd0);
    issue(4'd6, 32'd0, 32'd0);
    issue(4'd7, 32'd2, 32'd3);
`ifdef MULDIV_ACCUM_EN
    wait_idle(n);
    check("madd_busy_cycles", n, 32'd4);
    check("madd_hi", ReadDataHi, 32'h0000_0001);
    check("madd_lo", ReadDataLo, 32'h0000_0006);
    @(negedge Clk);
    issue(4'd9, 32'd2, 32'd3);
    wait_idle(n);
    check("msub_hi", ReadDataHi, 32'h0000_0001);
    check("msub_lo", ReadDataLo, 32'h0000_0000);
`else
    check("madd_off_busy", {31'd0, Busy}, 32'd0);
    @(negedge Clk);
    check("madd_off_hi", ReadDataHi, 32'h0000_0001);
    check("madd_off_lo", ReadDataLo, 32'h0000_0000);
    check("madd_off_done", {31'd0, Done}, 32'd0);
`endif

    @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
